// File: rtl/coreriscv_axi4_flow_through_deserializer_pkg.sv
// Shared Grant-channel definitions for the AXI4 bridge serializer/deserializer.
// Grant-type constants, block geometry, header bundle and multibeat decode.
package coreriscv_axi4_flow_through_deserializer_pkg;

  localparam int DATA_BEATS = 4;
  localparam int BEAT_BITS  = 64;
  localparam int CNT_BITS   = 2;

  localparam logic [3:0] GNT_VOLUNTARY_ACK  = 4'h0;
  localparam logic [3:0] GNT_PREFETCH_ACK   = 4'h1;
  localparam logic [3:0] GNT_PUT_ACK        = 4'h3;
  localparam logic [3:0] GNT_GET_DATA_BLOCK = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } des_state_e;

  typedef struct packed {
    logic       client_xact_id;
    logic [1:0] manager_xact_id;
    logic       is_builtin_type;
    logic [3:0] g_type;
  } gnt_hdr_t;

  // Coherence grants always carry a full block; builtin ones only for
  // GetDataBlock.
  function automatic logic is_multibeat(
    input logic       builtin,
    input logic [3:0] g_type
  );
    return builtin ? (g_type == GNT_GET_DATA_BLOCK) : 1'b1;
  endfunction

endpackage

// File: rtl/coreriscv_axi4_flow_through_deserializer_beat_buffer.sv
// Slot storage for a wide Grant message: SLOTS x W registers.
// Ports: clk, reset, wr_en (per slot), clr (zero unwritten slots), wr_data, data.
module coreriscv_axi4_beat_buffer #(
  parameter int SLOTS = 4,
  parameter int W     = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SLOTS-1:0]   wr_en,
  input  logic               clr,
  input  logic [W-1:0]       wr_data,
  output logic [SLOTS*W-1:0] data
);

  logic [W-1:0] slot_q [SLOTS];

  // A write wins over the clear, so the first beat of a message lands in
  // slot 0 while the other slots are zeroed in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (reset) begin
        slot_q[i] <= '0;
      end else if (wr_en[i]) begin
        slot_q[i] <= wr_data;
      end else if (clr) begin
        slot_q[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_out
    assign data[g*W +: W] = slot_q[g];
  end

endmodule

// File: rtl/coreriscv_axi4_flow_through_deserializer.sv
// Gathers DATA_BEATS Grant beats into one wide Grant; single-beat grants
// pass through one register stage zero-extended.
// Ports: clk/reset, io_in_* beat channel, io_out_* wide channel,
// io_cnt (next slot), io_done (completion pulse), io_err (sticky beat-index error).
module coreriscv_axi4_flow_through_deserializer
  import coreriscv_axi4_flow_through_deserializer_pkg::*;
#(
  parameter int DBEATS = DATA_BEATS,
  parameter int BBITS  = BEAT_BITS,
  parameter int CBITS  = CNT_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    io_in_ready,
  input  logic                    io_in_valid,
  input  logic [2:0]              io_in_bits_addr_beat,
  input  logic                    io_in_bits_client_xact_id,
  input  logic [1:0]              io_in_bits_manager_xact_id,
  input  logic                    io_in_bits_is_builtin_type,
  input  logic [3:0]              io_in_bits_g_type,
  input  logic [BBITS-1:0]        io_in_bits_data,
  input  logic                    io_out_ready,
  output logic                    io_out_valid,
  output logic [2:0]              io_out_bits_addr_beat,
  output logic                    io_out_bits_client_xact_id,
  output logic [1:0]              io_out_bits_manager_xact_id,
  output logic                    io_out_bits_is_builtin_type,
  output logic [3:0]              io_out_bits_g_type,
  output logic [DBEATS*BBITS-1:0] io_out_bits_data,
  output logic [CBITS-1:0]        io_cnt,
  output logic                    io_done,
  output logic                    io_err
);

  des_state_e        state_q, state_d;
  logic [CBITS-1:0]  cnt_q, cnt_d;
  gnt_hdr_t          hdr_q, hdr_in;
  logic              done_q, err_q;
  logic              fire_in, fire_out;
  logic              multi, first, last;
  logic [DBEATS-1:0] wr_en;

  assign io_out_valid = (state_q == ST_HOLD);
  assign io_in_ready  = !io_out_valid || io_out_ready;
  assign fire_in      = io_in_valid && io_in_ready;
  assign fire_out     = io_out_valid && io_out_ready;

  assign multi = is_multibeat(io_in_bits_is_builtin_type,
                              io_in_bits_g_type);

  // Any beat accepted outside FILL opens a new message, including one
  // accepted in HOLD while the previous message drains.
  assign first = fire_in && (state_q != ST_FILL);

  assign hdr_in = '{
    client_xact_id:  io_in_bits_client_xact_id,
    manager_xact_id: io_in_bits_manager_xact_id,
    is_builtin_type: io_in_bits_is_builtin_type,
    g_type:          io_in_bits_g_type
  };

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last    = 1'b0;
    if (state_q == ST_FILL) begin
      if (fire_in) begin
        if (cnt_q == CBITS'(DBEATS - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          last    = 1'b1;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
    end else begin
      if (fire_out) begin
        state_d = ST_IDLE;
      end
      if (fire_in) begin
        if (multi) begin
          state_d = ST_FILL;
          cnt_d   = CBITS'(1);
        end else begin
          state_d = ST_HOLD;
          last    = 1'b1;
        end
      end
    end
  end

  // Data always goes to the slot the counter points at, never to the
  // slot named by addr_beat.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DBEATS; i++) begin
      wr_en[i] = fire_in && (cnt_q == CBITS'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= last;
      if (first) begin
        hdr_q <= hdr_in;
      end
      if (fire_in && (io_in_bits_addr_beat != 3'(cnt_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  coreriscv_axi4_beat_buffer #(
    .SLOTS (DBEATS),
    .W     (BBITS)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .clr     (first),
    .wr_data (io_in_bits_data),
    .data    (io_out_bits_data)
  );

  assign io_out_bits_addr_beat       = 3'h0;
  assign io_out_bits_client_xact_id  = hdr_q.client_xact_id;
  assign io_out_bits_manager_xact_id = hdr_q.manager_xact_id;
  assign io_out_bits_is_builtin_type = hdr_q.is_builtin_type;
  assign io_out_bits_g_type          = hdr_q.g_type;
  assign io_cnt                      = cnt_q;
  assign io_done                     = done_q;
  assign io_err                      = err_q;

endmodule

// File: tb/tb_coreriscv_axi4_flow_through_deserializer.sv
// Testbench for the Grant deserializer: directed cases plus random
// back-to-back traffic against a message-level scoreboard.
module tb_coreriscv_axi4_flow_through_deserializer;

  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         io_in_ready;
  logic         io_in_valid = 1'b0;
  logic [2:0]   io_in_bits_addr_beat = '0;
  logic         io_in_bits_client_xact_id = 1'b0;
  logic [1:0]   io_in_bits_manager_xact_id = '0;
  logic         io_in_bits_is_builtin_type = 1'b0;
  logic [3:0]   io_in_bits_g_type = '0;
  logic [63:0]  io_in_bits_data = '0;
  logic         io_out_ready = 1'b1;
  logic         io_out_valid;
  logic [2:0]   io_out_bits_addr_beat;
  logic         io_out_bits_client_xact_id;
  logic [1:0]   io_out_bits_manager_xact_id;
  logic         io_out_bits_is_builtin_type;
  logic [3:0]   io_out_bits_g_type;
  logic [255:0] io_out_bits_data;
  logic [1:0]   io_cnt;
  logic         io_done;
  logic         io_err;

  coreriscv_axi4_flow_through_deserializer dut (
    .clk                         (clk),
    .reset                       (reset),
    .io_in_ready                 (io_in_ready),
    .io_in_valid                 (io_in_valid),
    .io_in_bits_addr_beat        (io_in_bits_addr_beat),
    .io_in_bits_client_xact_id   (io_in_bits_client_xact_id),
    .io_in_bits_manager_xact_id  (io_in_bits_manager_xact_id),
    .io_in_bits_is_builtin_type  (io_in_bits_is_builtin_type),
    .io_in_bits_g_type           (io_in_bits_g_type),
    .io_in_bits_data             (io_in_bits_data),
    .io_out_ready                (io_out_ready),
    .io_out_valid                (io_out_valid),
    .io_out_bits_addr_beat       (io_out_bits_addr_beat),
    .io_out_bits_client_xact_id  (io_out_bits_client_xact_id),
    .io_out_bits_manager_xact_id (io_out_bits_manager_xact_id),
    .io_out_bits_is_builtin_type (io_out_bits_is_builtin_type),
    .io_out_bits_g_type          (io_out_bits_g_type),
    .io_out_bits_data            (io_out_bits_data),
    .io_cnt                      (io_cnt),
    .io_done                     (io_done),
    .io_err                      (io_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   hdr;
  } msg_t;

  msg_t         q[$];
  int           part_n = 0;
  int           part_need = 1;
  logic [255:0] part_data = '0;
  logic [7:0]   part_hdr = '0;
  bit           m_done = 0;
  bit           m_err = 0;
  int           n_out = 0;
  bit           rnd = 0;

  // Message-level reference: beats collect in arrival order, a message
  // is complete after 4 beats (block grants) or 1 beat (other builtins).
  always @(negedge clk) begin
    msg_t e;
    if (reset) begin
      q.delete();
      part_n = 0;
      m_done = 0;
      m_err  = 0;
    end else begin
      chk("cnt", 256'(io_cnt), 256'(part_n));
      chk("done", 256'(io_done), 256'(m_done));
      chk("err", 256'(io_err), 256'(m_err));
      chk("out_valid", 256'(io_out_valid), 256'(q.size() != 0));
      chk("in_ready", 256'(io_in_ready),
          256'(q.size() == 0 || io_out_ready));
      m_done = 0;
      if (io_out_valid && io_out_ready && q.size() != 0) begin
        e = q.pop_front();
        n_out++;
        chk("out_data", io_out_bits_data, e.data);
        chk("out_hdr", 256'({io_out_bits_client_xact_id,
                             io_out_bits_manager_xact_id,
                             io_out_bits_is_builtin_type,
                             io_out_bits_g_type}), 256'(e.hdr));
        chk("out_addr", 256'(io_out_bits_addr_beat), 256'(0));
      end
      if (io_in_valid && io_in_ready) begin
        if (part_n == 0) begin
          part_hdr  = {io_in_bits_client_xact_id,
                       io_in_bits_manager_xact_id,
                       io_in_bits_is_builtin_type,
                       io_in_bits_g_type};
          part_data = '0;
          part_need = (!io_in_bits_is_builtin_type ||
                       io_in_bits_g_type == 4'h4) ? NB : 1;
        end
        part_data[part_n*64 +: 64] = io_in_bits_data;
        if (io_in_bits_addr_beat != 3'(part_n)) m_err = 1;
        part_n++;
        if (part_n == part_need) begin
          e.data = part_data;
          e.hdr  = part_hdr;
          q.push_back(e);
          part_n = 0;
          m_done = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) io_out_ready = 1'($urandom % 2);
  endtask

  task automatic put(input logic [2:0] a, input logic b,
                     input logic [3:0] g, input logic [63:0] d,
                     input logic c, input logic [1:0] m);
    bit ok = 0;
    io_in_valid                = 1'b1;
    io_in_bits_addr_beat       = a;
    io_in_bits_is_builtin_type = b;
    io_in_bits_g_type          = g;
    io_in_bits_data            = d;
    io_in_bits_client_xact_id  = c;
    io_in_bits_manager_xact_id = m;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (io_in_ready) ok = 1;
      step();
    end
    io_in_valid = 1'b0;
    if (!ok) chk("in_timeout", 256'(0), 256'(1));
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    io_in_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [2:0] ord [4];
  logic [3:0] gsel [3];

  initial begin
    int base;
    logic b;
    logic [3:0] g;
    int need;
    ord  = '{3'd0, 3'd2, 3'd1, 3'd3};
    gsel = '{4'h3, 4'h4, 4'h0};

    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 256'(io_out_valid), 256'(0));
    chk("rst_in_ready", 256'(io_in_ready), 256'(1));
    chk("rst_cnt", 256'(io_cnt), 256'(0));
    chk("rst_data", io_out_bits_data, 256'(0));
    chk("rst_hdr", 256'({io_out_bits_client_xact_id,
                         io_out_bits_manager_xact_id,
                         io_out_bits_is_builtin_type,
                         io_out_bits_g_type}), 256'(0));
    step();

    // 4-beat GetDataBlock
    for (int k = 0; k < 4; k++)
      put(3'(k), 1'b1, 4'h4, {16{4'(k + 1)}}, 1'b1, 2'd2);
    @(negedge clk);
    chk("blk_valid", 256'(io_out_valid), 256'(1));
    chk("blk_done", 256'(io_done), 256'(1));
    chk("blk_data", io_out_bits_data,
        {64'h4444444444444444, 64'h3333333333333333,
         64'h2222222222222222, 64'h1111111111111111});
    step();

    // single-beat PutAck
    put(3'd0, 1'b1, 4'h3, 64'hABCD, 1'b0, 2'd1);
    @(negedge clk);
    chk("ack_valid", 256'(io_out_valid), 256'(1));
    chk("ack_data", io_out_bits_data, 256'hABCD);
    chk("ack_cnt", 256'(io_cnt), 256'(0));
    step();

    // stall in HOLD, then release with a new beat 0
    io_out_ready = 1'b0;
    put(3'd0, 1'b1, 4'h3, 64'h5A5A, 1'b1, 2'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 256'(io_out_valid), 256'(1));
      chk("hold_in_ready", 256'(io_in_ready), 256'(0));
      chk("hold_data", io_out_bits_data, 256'h5A5A);
    end
    step();
    io_out_ready = 1'b1;
    put(3'd0, 1'b1, 4'h4, 64'hC0, 1'b0, 2'd0);
    @(negedge clk);
    chk("rel_valid", 256'(io_out_valid), 256'(0));
    chk("rel_cnt", 256'(io_cnt), 256'(1));
    step();
    for (int k = 1; k < 4; k++)
      put(3'(k), 1'b1, 4'h4, 64'(8'hC0 + k), 1'b0, 2'd0);
    step();

    // reset in the middle of a fill
    for (int k = 0; k < 3; k++)
      put(3'(k), 1'b1, 4'h4, 64'hDEAD0 + 64'(k), 1'b1, 2'd1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_valid", 256'(io_out_valid), 256'(0));
    chk("mid_rst_cnt", 256'(io_cnt), 256'(0));
    step();
    for (int k = 0; k < 4; k++)
      put(3'(k), 1'b0, 4'h9, 64'hF0 + 64'(k), 1'b0, 2'd2);
    @(negedge clk);
    chk("clean_data", io_out_bits_data,
        {64'hF3, 64'hF2, 64'hF1, 64'hF0});
    step();

    // out-of-order beat indices
    for (int k = 0; k < 4; k++)
      put(ord[k], 1'b1, 4'h4, 64'h10 + 64'(k), 1'b0, 2'd0);
    @(negedge clk);
    chk("ooo_err", 256'(io_err), 256'(1));
    chk("ooo_data", io_out_bits_data,
        {64'h13, 64'h12, 64'h11, 64'h10});
    step();
    put(3'd0, 1'b1, 4'h3, 64'h77, 1'b0, 2'd0);
    step();
    @(negedge clk);
    chk("err_sticky", 256'(io_err), 256'(1));
    step();
    do_reset();
    @(negedge clk);
    chk("err_clr", 256'(io_err), 256'(0));
    step();

    // random back-to-back traffic
    rnd  = 1;
    base = n_out;
    for (int m = 0; m < 8; m++) begin
      b = 1'($urandom % 2);
      g = b ? gsel[$urandom % 3] : 4'($urandom % 16);
      need = (!b || g == 4'h4) ? NB : 1;
      for (int k = 0; k < need; k++) begin
        put(3'(k), b, g, {$urandom, $urandom},
            1'($urandom % 2), 2'($urandom % 4));
        if ($urandom % 4 == 0) step();
      end
    end
    rnd = 0;
    io_out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("drain_empty", 256'(q.size()), 256'(0));
    chk("rand_msgs", 256'(n_out - base), 256'(8));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
